sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
Downstream consumer of the parametric adder's `sum` output. It accepts a stream of WIDTH-bit sums over a valid/ready handshake and accumulates COUNT beats into one widened total. It presents that total on a valid/ready output port and holds it until the output is taken. It is the first clocked stage after the combinational adder and feeds the result/logging logic.

Parameters:
WIDTH, 8, width of each input beat; matches the adder WIDTH.
COUNT, 4, number of beats per frame; legal range 1..256.
ACC_WIDTH, 10, width of the accumulated total; must be ≥ WIDTH + ceil(log2(COUNT)), so the total never wraps.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
clear  input  1  synchronous frame abort.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  WIDTH  unsigned sum from the adder.
out_valid  output  1  out_data holds a completed frame total.
out_ready  input  1  downstream accepts out_data this cycle.
out_data  output  ACC_WIDTH  unsigned frame total.

Behaviour:
- Reset (rst_n=0, takes effect asynchronously): state=ACCUM, acc=0, beat count=0, out_valid=0, out_data=0, in_ready=1 once rst_n deasserts. A reset during HOLD drops out_valid immediately and discards the frame.
- Clock and reset: one clock domain, clk; reset is asynchronous and active-low, rst_n.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat acceptance: a beat is taken only when in_valid & in_ready are both high at the edge. in_valid gaps are legal; acc and count hold across gaps.
- ACCUM, accepted beat with cnt < COUNT-1: acc <= acc + zero-extended in_data; cnt <= cnt+1.
- ACCUM, accepted beat with cnt == COUNT-1: out_data <= acc + in_data; out_valid <= 1; state <= HOLD; acc <= 0; cnt <= 0.
- Latency: out_valid rises on the edge that accepts the last beat, i.e. one cycle after that beat is presented.
- HOLD: out_data and out_valid stay stable while out_ready=0. On out_valid & out_ready: out_valid <= 0; state <= ACCUM. out_data keeps its last value; it is not cleared.
- Throughput: one bubble cycle per frame; in_ready stays 0 through HOLD, including the handshake cycle.
- COUNT=1: every accepted beat goes straight to HOLD with out_data = in_data.
- Arithmetic: unsigned only. Zero-extend in_data to ACC_WIDTH before adding. Overflow cannot occur by the ACC_WIDTH constraint; no saturation logic.
- clear=1 (synchronous; priority below reset, above everything else): acc=0, cnt=0, out_valid=0, state=ACCUM. A beat offered in the same cycle is dropped, not counted. A pending HOLD result is discarded. out_data keeps its last value.
- Simultaneous out handshake and in_valid in HOLD: the output handshake completes; the input beat is not accepted because in_ready=0.

Decomposition:
- Shared header sum_accum_defs.vh: state encodings (ACCUM=1'b0, HOLD=1'b1), default WIDTH/COUNT/ACC_WIDTH values.
- One natural sub-module: beat_counter (parameter COUNT; inputs clk, rst_n, clr, inc; outputs cnt and last = (cnt==COUNT-1)). The FSM and accumulator stay in sum_accumulator.

Test Plan:
(WIDTH=8, COUNT=4, ACC_WIDTH=10 unless stated)
1. Basic frame: beats 10,20,30,40 on consecutive cycles, out_ready=1 -> out_valid for exactly 1 cycle with out_data=100; in_ready=0 that cycle, then 1.
2. Full scale: four beats of 255 -> out_data=1020 (0x3FC), no wrap; next frame 1,1,1,1 -> out_data=4.
3. Backpressure and gaps: in_valid toggled 1,0,1,0,1,1 with values 5,6,7,8; out_ready=0 for 5 cycles -> out_valid stays 1, out_data stays 26, in_ready stays 0; out_ready=1 -> out_valid drops on the next edge.
4. Clear: accept 50,60, assert clear together with beat 70 -> 70 dropped; then 1,2,3,4 -> out_data=10.
5. Async reset: rst_n pulled low mid-cycle during HOLD -> out_valid=0 and out_data=0 without waiting for clk; after release, 3,3,3,3 -> out_data=12.
6. COUNT=1 build: beats 9 then 200, out_ready=1 -> two results 9 and 200, each one cycle after its beat, with a bubble cycle between them.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and default sizing for the sum accumulator and its beat counter.
package sum_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_COUNT     = 4;
    localparam int DEF_ACC_WIDTH = 10;

    // Counter width that still works for a single-beat frame.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sum_accumulator_beat_counter.sv
// Counts accepted beats within a frame and flags the final beat.
module beat_counter
    import sum_accumulator_pkg::*;
#(
    parameter int COUNT = DEF_COUNT,
    parameter int CW    = cnt_width(COUNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT input beats into one widened total and holds it on a
// valid/ready output until taken. A beat or a result transfers only on a
// rising edge where that port's valid and ready are both high.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int COUNT     = DEF_COUNT,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data
);

    localparam int CW = cnt_width(COUNT);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] beat_ext;
    logic [CW-1:0]        cnt;
    logic                 last;
    logic                 accept;

    assign in_ready = (state == ACCUM);
    assign beat_ext = ACC_WIDTH'(in_data);
    // A beat offered alongside clear is dropped, so it must not advance the count.
    assign accept   = in_valid & in_ready & ~clear;

    beat_counter #(
        .COUNT (COUNT),
        .CW    (CW)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (accept),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            out_data  <= acc + beat_ext;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                            acc       <= '0;
                        end else begin
                            acc <= acc + beat_ext;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a COUNT=4 instance and a COUNT=1 instance.
module tb_sum_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;

    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] in1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;

    int checks;
    int failures;

    sum_accumulator #(.WIDTH(8), .COUNT(4), .ACC_WIDTH(10)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    sum_accumulator #(.WIDTH(8), .COUNT(1), .ACC_WIDTH(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (1'b0),
        .in_valid  (in1_valid),
        .in_ready  (in1_ready),
        .in_data   (in1_data),
        .out_valid (out1_valid),
        .out_ready (out1_ready),
        .out_data  (out1_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        in1_valid = 1'b0;
        in1_data  = '0;
        out1_ready = 1'b1;

        #10;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        #2 rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 1);

        // 1: basic frame
        beat(10); beat(20); beat(30); beat(40);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 100);
        check("t1_in_ready_hold", 32'(in_ready), 0);
        idle();
        check("t1_valid_drop", 32'(out_valid), 0);
        check("t1_in_ready_back", 32'(in_ready), 1);

        // 2: full scale, then small frame
        beat(255); beat(255); beat(255); beat(255);
        check("t2_full_data", 32'(out_data), 1020);
        idle();
        beat(1); beat(1); beat(1); beat(1);
        check("t2_small_data", 32'(out_data), 4);
        idle();

        // 3: gaps and backpressure; the ignored 99s also probe HOLD input gating
        out_ready = 1'b0;
        beat(5); idle(); beat(6); idle(); beat(7); beat(8);
        check("t3_valid", 32'(out_valid), 1);
        check("t3_data", 32'(out_data), 26);
        in_valid = 1'b1;
        in_data  = 99;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_data", 32'(out_data), 26);
            check("t3_hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        check("t3_release", 32'(out_valid), 0);
        in_valid = 1'b0;

        // 4: clear drops the concurrent beat and the partial frame
        beat(50); beat(60);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 70;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t4_clear_valid", 32'(out_valid), 0);
        check("t4_clear_in_ready", 32'(in_ready), 1);
        beat(1); beat(2); beat(3); beat(4);
        check("t4_data", 32'(out_data), 10);
        idle();

        // clear during HOLD discards the result but keeps out_data
        out_ready = 1'b0;
        beat(1); beat(1); beat(1); beat(1);
        check("t4b_valid", 32'(out_valid), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4b_cleared_valid", 32'(out_valid), 0);
        check("t4b_kept_data", 32'(out_data), 4);
        check("t4b_in_ready", 32'(in_ready), 1);

        // 5: asynchronous reset during HOLD
        beat(7); beat(7); beat(7); beat(7);
        check("t5_pre_data", 32'(out_data), 28);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 0);
        check("t5_async_data", 32'(out_data), 0);
        #1 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        check("t5_in_ready", 32'(in_ready), 1);
        beat(3); beat(3); beat(3); beat(3);
        check("t5_valid", 32'(out_valid), 1);
        check("t5_data", 32'(out_data), 12);
        idle();

        // 6: COUNT=1 instance, one bubble between results
        in1_valid = 1'b1;
        in1_data  = 9;
        step();
        check("t6_first_valid", 32'(out1_valid), 1);
        check("t6_first_data", 32'(out1_data), 9);
        check("t6_first_in_ready", 32'(in1_ready), 0);
        in1_data = 200;
        step();
        check("t6_bubble_valid", 32'(out1_valid), 0);
        check("t6_bubble_in_ready", 32'(in1_ready), 1);
        step();
        check("t6_second_valid", 32'(out1_valid), 1);
        check("t6_second_data", 32'(out1_data), 200);
        in1_valid = 1'b0;
        step();
        check("t6_end_valid", 32'(out1_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
